serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller. It loads two WIDTH-bit operands on a start request and sequences one shared 1-bit add cell (half-adder pair plus a carry flip-flop) across all bit positions, LSB first. When the operation completes it presents the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting FSM or testbench and the add datapath, trading WIDTH cycles of latency for a single bit-slice of adder hardware.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; sampled on the edge that accepts start.
- b  input  WIDTH  operand B; sampled on the edge that accepts start.
- sub  input  1  operation select, 1 = A−B; sampled with start. Functional only when SERIAL_SUB_EN is defined.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  registered result.
- c_out  output  1  registered carry-out of the MSB slice.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE or DONE with start=1 (accepted start):
  - latch a and b (b complemented when subtracting);
  - set carry to 0 for add, 1 for subtract;
  - clear the bit counter;
  - go to RUN.
- DONE with start=0: go to IDLE.
- RUN, every cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry;
  - carry ← majority(a_sh[0], b_sh[0], carry);
  - s is shifted into the MSB of the internal result register, which shifts right;
  - a_sh and b_sh shift right;
  - the counter increments.
- RUN exit: on the cycle that processes bit WIDTH−1:
  - copy the full result register to sum;
  - copy the final carry to c_out;
  - go to DONE.
- Outputs by state:
  - done = 1 only in DONE;
  - busy = 1 only in RUN.
- sum and c_out keep the previous result throughout RUN. They change only on the edge entering DONE.
- start while busy: ignored, with no effect on the operation in flight or on the latched operands.
- Arithmetic:
  - sum = (A + B) mod 2^WIDTH;
  - c_out = bit WIDTH of the full-width sum;
  - no sign handling and no overflow flag.
- Reset (asynchronous, at any time, including mid-RUN):
  - state goes to IDLE;
  - busy, done, sum, c_out, carry, counter and shift registers all go to 0;
  - the partial result is discarded.

## Timing
- Edge 0 accepts start. Bits are processed on edges 1 to WIDTH.
- The edge-WIDTH transition enters DONE. done is high for the cycle after edge WIDTH, so latency from the accepting edge to done is WIDTH cycles.
- busy is high from the cycle after edge 0 up to and including edge WIDTH.
- Back-to-back: start held high in DONE is accepted on that same edge, giving one result every WIDTH+1 cycles.
- WIDTH=1: a single RUN cycle, then DONE.
- Deassertion of rst is synchronous to the first following clock edge. No operation is accepted on the edge at which rst is still high.

## Configuration
- SERIAL_SUB_EN defined:
  - sub=1 with an accepted start computes A + ~B + 1;
  - c_out = 1 means no borrow (A ≥ B unsigned).
- SERIAL_SUB_EN undefined:
  - the sub port is present but ignored;
  - carry-in is always 0;
  - b is never complemented.

## Test plan
- Basic add, WIDTH=8: start with a=0x35, b=0x4A → done exactly 8 cycles after the accepting edge, sum=0x7F, c_out=0, busy high for 8 cycles.
- Carry wrap: a=0xFF, b=0x01 → sum=0x00, c_out=1. Then a=0xFF, b=0xFF → sum=0xFE, c_out=1.
- Start while busy: pulse start with a=0x01, b=0x01 at RUN cycle 3 of a 0x10+0x20 operation → result sum=0x30. Exactly one done pulse; the second request is dropped.
- Reset mid-operation: assert rst at RUN cycle 4 → busy, done, sum and c_out all 0 immediately. A new start after release completes normally.
- Subtract, with SERIAL_SUB_EN:
  - 0x10−0x01 → sum=0x0F, c_out=1;
  - 0x01−0x02 → sum=0xFF, c_out=0.
  - Without the macro, sub=1 with 0x10, 0x01 gives sum=0x11.
- Back-to-back: hold start high with alternating operands → done every 9 cycles, each sum correct. sum stays stable during RUN.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared 1-bit add cell is sequenced LSB first over WIDTH cycles.
// Optional macro SERIAL_SUB_EN makes sub=1 compute A + ~B + 1 (c_out=1 means no borrow).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             bit_sum;
    logic             carry_next;
    logic             res_drop_unused;
    logic [WIDTH-1:0] b_load;
    logic             carry_in;

`ifdef SERIAL_SUB_EN
    assign b_load   = sub ? ~b : b;
    assign carry_in = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_load     = b;
    assign carry_in   = 1'b0;
`endif

    // The single bit-slice: full-adder sum and majority carry.
    always_comb begin
        bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // New bit enters at the MSB; the oldest bit falls off the LSB after WIDTH shifts.
    assign {res_next, res_drop_unused} = {bit_sum, res};

    // NOTE: every register here is state, so only non-blocking assignments are used; reads
    // within the block see the pre-edge values, which is what the shift/carry chain relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_in;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    res   <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        sum   <= res_next;
                        c_out <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
